// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - flag indices and default sizing for the condition code register
package ccr_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int CCR_FLAG_W     = 4;
  localparam int CCR_SAVE_DEPTH = 4;

endpackage

// File: rtl/ccr_save_stack.sv
// rtl/ccr_save_stack.sv - LIFO of saved CCR frames with depth counter and full/empty flags
module ccr_save_stack
  import ccr_pkg::*;
#(
  parameter int FLAG_W     = CCR_FLAG_W,
  parameter int SAVE_DEPTH = CCR_SAVE_DEPTH,
  parameter int DEPTH_W    = $clog2(SAVE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] push_data,
  output logic [FLAG_W-1:0] top,
  output logic [DEPTH_W-1:0] depth,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

  logic [FLAG_W-1:0]  slots [SAVE_DEPTH];
  logic               pop_ok;
  logic               push_ok;
  logic [DEPTH_W-1:0] depth_nxt;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   push_idx;

  // A successful pop suppresses the push entirely, including its overflow report.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && !pop_ok && !full;
  assign overflow  = push && !pop_ok && full;
  assign underflow = pop && empty;

  assign top_idx  = IDX_W'(depth - DEPTH_W'(1));
  assign push_idx = IDX_W'(depth);
  assign top      = slots[top_idx];

  always_comb begin
    depth_nxt = depth;
    if (pop_ok) begin
      depth_nxt = depth - DEPTH_W'(1);
    end else if (push_ok) begin
      depth_nxt = depth + DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      depth <= depth_nxt;
      full  <= (depth_nxt == DEPTH_W'(SAVE_DEPTH));
      empty <= (depth_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      slots[push_idx] <= push_data;
    end
  end

endmodule

// File: rtl/ccr_stack.sv
// rtl/ccr_stack.sv - condition code register with masked merge and nested save/restore; CCR_STACK_BYPASS_EN adds ccr_fwd
module ccr_stack
  import ccr_pkg::*;
#(
  parameter int FLAG_W     = CCR_FLAG_W,
  parameter int SAVE_DEPTH = CCR_SAVE_DEPTH,
  parameter int DEPTH_W    = $clog2(SAVE_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_valid,
  input  logic [FLAG_W-1:0]  wb_flags,
  input  logic [FLAG_W-1:0]  wb_mask,
  input  logic               set_valid,
  input  logic [FLAG_W-1:0]  set_mask,
  input  logic               clr_valid,
  input  logic [FLAG_W-1:0]  clr_mask,
  input  logic               save_req,
  input  logic               restore_req,
  input  logic               err_clear,
  output logic [FLAG_W-1:0]  ccr_out,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               err_overflow,
  output logic               err_underflow
`ifdef CCR_STACK_BYPASS_EN
  ,
  output logic [FLAG_W-1:0]  ccr_fwd
`endif
);

  logic [FLAG_W-1:0] merged;
  logic [FLAG_W-1:0] ccr_nxt;
  logic [FLAG_W-1:0] stack_top;
  logic              restore_ok;
  logic              ovf_pulse;
  logic              unf_pulse;

  always_comb begin
    merged = ccr_out;
    if (wb_valid) begin
      merged = (merged & ~wb_mask) | (wb_flags & wb_mask);
    end
    if (set_valid) begin
      merged = merged | set_mask;
    end
    if (clr_valid) begin
      merged = merged & ~clr_mask;
    end
  end

  assign restore_ok = restore_req && !stack_empty;

  always_comb begin
    ccr_nxt = merged;
    if (reset) begin
      ccr_nxt = '0;
    end else if (restore_ok) begin
      ccr_nxt = stack_top;
    end
  end

  // The post-merge value is pushed so a retiring instruction's flags survive interrupt entry.
  ccr_save_stack #(
    .FLAG_W     (FLAG_W),
    .SAVE_DEPTH (SAVE_DEPTH),
    .DEPTH_W    (DEPTH_W)
  ) u_save_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (save_req),
    .pop       (restore_req),
    .push_data (merged),
    .top       (stack_top),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (ovf_pulse),
    .underflow (unf_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ccr_out       <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      ccr_out       <= ccr_nxt;
      err_overflow  <= ovf_pulse | (err_overflow & ~err_clear);
      err_underflow <= unf_pulse | (err_underflow & ~err_clear);
    end
  end

`ifdef CCR_STACK_BYPASS_EN
  assign ccr_fwd = ccr_nxt;
`endif

endmodule

// File: tb/tb_ccr_stack.sv
// tb/tb_ccr_stack.sv - directed self-checking bench for ccr_stack
module tb_ccr_stack;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_valid;
  logic [3:0] wb_flags;
  logic [3:0] wb_mask;
  logic       set_valid;
  logic [3:0] set_mask;
  logic       clr_valid;
  logic [3:0] clr_mask;
  logic       save_req;
  logic       restore_req;
  logic       err_clear;
  logic [3:0] ccr_out;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
  logic       err_overflow;
  logic       err_underflow;
`ifdef CCR_STACK_BYPASS_EN
  logic [3:0] ccr_fwd;
  logic [3:0] fwd_seen;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ccr_stack dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_flags      (wb_flags),
    .wb_mask       (wb_mask),
    .set_valid     (set_valid),
    .set_mask      (set_mask),
    .clr_valid     (clr_valid),
    .clr_mask      (clr_mask),
    .save_req      (save_req),
    .restore_req   (restore_req),
    .err_clear     (err_clear),
    .ccr_out       (ccr_out),
    .depth         (depth),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef CCR_STACK_BYPASS_EN
    ,
    .ccr_fwd       (ccr_fwd)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wb_valid = 1'b0; wb_flags = '0; wb_mask = '0;
    set_valid = 1'b0; set_mask = '0; clr_valid = 1'b0; clr_mask = '0;
    save_req = 1'b0; restore_req = 1'b0; err_clear = 1'b0;
  endtask

  // Applies the currently driven inputs for one rising edge, then returns inputs to idle.
  task automatic step();
    @(negedge clk);
`ifdef CCR_STACK_BYPASS_EN
    fwd_seen = ccr_fwd;
`endif
    @(posedge clk);
    #1;
`ifdef CCR_STACK_BYPASS_EN
    check("ccr_fwd", 32'(ccr_out), 32'(fwd_seen));
`endif
    idle_inputs();
  endtask

  task automatic wb(input logic [3:0] f, input logic [3:0] m);
    wb_valid = 1'b1; wb_flags = f; wb_mask = m;
  endtask

  task automatic check_state(input string tag, input logic [3:0] c, input logic [2:0] d,
                             input logic f, input logic e, input logic ov, input logic un);
    check({tag, ".ccr"}, 32'(ccr_out), 32'(c));
    check({tag, ".depth"}, 32'(depth), 32'(d));
    check({tag, ".full"}, 32'(stack_full), 32'(f));
    check({tag, ".empty"}, 32'(stack_empty), 32'(e));
    check({tag, ".ovf"}, 32'(err_overflow), 32'(ov));
    check({tag, ".unf"}, 32'(err_underflow), 32'(un));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b1;
    step();
    check_state("reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    wb(4'b1111, 4'b0101); step();
    check("wb1", 32'(ccr_out), 32'(4'b0101));
    wb(4'b0000, 4'b0001); step();
    check("wb2", 32'(ccr_out), 32'(4'b0100));

    clr_valid = 1'b1; clr_mask = 4'b1111; step();
    check("clr_all", 32'(ccr_out), 32'(4'b0000));
    set_valid = 1'b1; set_mask = 4'b1010; clr_valid = 1'b1; clr_mask = 4'b0010; step();
    check("set_clr", 32'(ccr_out), 32'(4'b1000));

    wb(4'b0011, 4'b1111); step();
    check("wb3", 32'(ccr_out), 32'(4'b0011));
    wb(4'b1100, 4'b1111); save_req = 1'b1; step();
    check_state("save_merge", 4'b1100, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_valid = 1'b1; clr_mask = 4'b1111; step();
    check("clr_after_save", 32'(ccr_out), 32'(4'b0000));
    restore_req = 1'b1; step();
    check_state("restore1", 4'b1100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int v = 1; v <= 4; v++) begin
      wb(4'(v), 4'b1111); save_req = 1'b1; step();
    end
    check_state("fill", 4'd4, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    wb(4'd5, 4'b1111); save_req = 1'b1; step();
    check_state("overflow", 4'd5, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int v = 4; v >= 1; v--) begin
      restore_req = 1'b1; step();
      check("pop_val", 32'(ccr_out), 32'(v));
      check("pop_depth", 32'(depth), 32'(v - 1));
    end
    check_state("drained", 4'd1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    err_clear = 1'b1; step();
    check("ovf_clear", 32'(err_overflow), 32'(0));

    wb(4'b0110, 4'b1111); restore_req = 1'b1; step();
    check_state("underflow", 4'b0110, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    restore_req = 1'b1; err_clear = 1'b1; step();
    check("unf_clear_vs_new", 32'(err_underflow), 32'(1));
    err_clear = 1'b1; step();
    check("unf_clear", 32'(err_underflow), 32'(0));

    save_req = 1'b1; step();
    check("push_0110", 32'(depth), 32'(1));
    wb(4'b1111, 4'b1111); save_req = 1'b1; restore_req = 1'b1; step();
    check_state("save_restore_full", 4'b0110, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    wb(4'b0011, 4'b1111); save_req = 1'b1; restore_req = 1'b1; step();
    check_state("save_restore_empty", 4'b0011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    clr_valid = 1'b1; clr_mask = 4'b1111; restore_req = 1'b1; step();
    check("pop_after_sr", 32'(ccr_out), 32'(4'b0011));

    wb(4'b1001, 4'b1111); save_req = 1'b1; step();
    save_req = 1'b1; step();
    check("depth2", 32'(depth), 32'(2));
    reset = 1'b1; save_req = 1'b1; wb(4'b1111, 4'b1111); step();
    check_state("mid_reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    restore_req = 1'b1; step();
    check("post_reset_pop", 32'(err_underflow), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccr_stack.md
Name: ccr_stack

Overview:
Parametrised condition code register for the pipelined core.
- Accepts masked flag updates from MEM/WB and explicit flag set/clear operations (SETC/CLRC-style).
- Holds a LIFO shadow stack of CCR values so interrupt entry saves flags and RTI restores them, with nesting.
- Sits at the writeback boundary and feeds ccr_out to the branch unit and the execute-stage flag merge.

Parameters:
FLAG_W, 4, number of condition flags. Bit order is Z=0, N=1, C=2, V=3; extra bits are user-defined.
SAVE_DEPTH, 4, number of nested CCR save slots (minimum 1).
DEPTH_W, $clog2(SAVE_DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
wb_valid  in  1  MEM/WB stage carries a flag-writing instruction
wb_flags  in  FLAG_W  flag values from MEM/WB
wb_mask  in  FLAG_W  per-flag write enable for wb_flags (1 = update)
set_valid  in  1  apply set_mask
set_mask  in  FLAG_W  flags forced to 1
clr_valid  in  1  apply clr_mask
clr_mask  in  FLAG_W  flags forced to 0
save_req  in  1  interrupt entry: push CCR
restore_req  in  1  RTI: pop CCR
err_clear  in  1  clears the sticky error bits
ccr_out  out  FLAG_W  architectural CCR
depth  out  DEPTH_W  number of occupied save slots
stack_full  out  1  depth == SAVE_DEPTH
stack_empty  out  1  depth == 0
err_overflow  out  1  sticky: a push was dropped
err_underflow  out  1  sticky: a pop was attempted on an empty stack
ccr_fwd  out  FLAG_W  next-cycle CCR value; present only when the optional feature is enabled

Behaviour:
Reset:
- ccr_out=0, depth=0, stack_full=0, stack_empty=1, both error bits 0.
- Stack contents are don't-care.
- Reset overrides all other inputs in the same cycle. Reset mid-nesting discards all saved frames.

Merge value m, computed combinationally each cycle:
- m = ccr_out.
- If wb_valid: m = (m & ~wb_mask) | (wb_flags & wb_mask).
- Then if set_valid: m |= set_mask.
- Then if clr_valid: m &= ~clr_mask. Clear wins over set on the same bit.

Next CCR, by priority:
- If restore_req and not empty: ccr_out <= top of stack; depth decrements; m is discarded.
- Otherwise ccr_out <= m.
- Latency: one cycle from input to ccr_out. No combinational path from inputs to ccr_out.

Save:
- If save_req, not full, and no valid restore this cycle: push m (the post-merge value, so the flags of an instruction retiring on interrupt entry are preserved); depth increments.
- save_req when full: no push, err_overflow <= 1; the CCR still updates to m.

Restore on empty:
- err_underflow <= 1. The CCR updates to m as if there were no restore.

Simultaneous save_req and restore_req:
- Restore (if non-empty) is performed and the save is ignored; err_overflow is not set.
- If the stack is empty: the underflow rule applies and the push then proceeds normally.

Error bits:
- Sticky until err_clear or reset.
- If err_clear and a new error occur in the same cycle, the new error wins (bit = 1).

Flags:
- stack_full and stack_empty are registered and consistent with depth in the same cycle.

Optional Feature:
CCR_STACK_BYPASS_EN
- Defined: ccr_fwd port exists and equals the value ccr_out will take at the next edge (including the restore and reset cases; 0 while reset is high). The execute stage uses it to avoid a one-cycle flag hazard.
- Undefined: no ccr_fwd port and no bypass logic. The pipeline must stall one cycle on a flag dependence.

Decomposition:
Package ccr_pkg:
- Flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- Default FLAG_W and SAVE_DEPTH.

Sub-module ccr_save_stack:
- Parametrised LIFO holding SAVE_DEPTH x FLAG_W entries, a depth counter, and full/empty flags.
- Push/pop with rules: pop has priority, push is ignored when full, pop is ignored when empty.
- Reports overflow/underflow pulses to the parent, which owns the sticky bits and the merge.

Test Plan:
1. Reset then wb_valid=1, wb_flags=4'b1111, wb_mask=4'b0101 -> next cycle ccr_out=4'b0101; a second write with flags=0000, mask=0001 -> ccr_out=4'b0100.
2. ccr_out=0000; set_valid with mask=1010 and clr_valid with mask=0010 in the same cycle -> ccr_out=1000.
3. ccr_out=0011; save_req with wb_valid (flags=1100, mask=1111) in the same cycle -> ccr_out=1100 and depth=1; then clr mask=1111 -> ccr_out=0000; then restore_req -> ccr_out=1100, depth=0, stack_empty=1.
4. SAVE_DEPTH=4: push values 1,2,3,4, then a 5th save_req -> depth stays 4, stack_full=1, err_overflow=1; four restores return 4,3,2,1 in order.
5. Empty stack: restore_req with wb_valid (flags=0110, mask=1111) -> ccr_out=0110, err_underflow=1; err_clear -> error bit returns to 0.
6. depth=2; assert reset together with save_req -> next cycle ccr_out=0, depth=0, stack_empty=1, no errors. With CCR_STACK_BYPASS_EN defined, ccr_fwd matches ccr_out one cycle later across scenarios 1-5.
